// File: rtl/dct_pkg.sv
// Shared constants and saturation helper for the row DCT input stage,
// the DA_z* coefficient units and the transpose buffer.
package dct_pkg;

    localparam int DCT_N  = 8;
    localparam int DA_W   = 12;
    localparam int DA_MAX = 2047;
    localparam int DA_MIN = -2048;

    function automatic logic signed [DA_W-1:0] sat_da(input int v);
        if (v > DA_MAX)
            return DA_W'(DA_MAX);
        else if (v < DA_MIN)
            return DA_W'(DA_MIN);
        else
            return DA_W'(v);
    endfunction

endpackage

// File: rtl/dct_bfly_pair.sv
// One butterfly pair: saturated sum and difference of two signed samples.
module dct_bfly_pair
    import dct_pkg::*;
#(
    parameter int SW = 9
) (
    input  logic signed [SW-1:0]   a,
    input  logic signed [SW-1:0]   b,
    output logic signed [DA_W-1:0] sum,
    output logic signed [DA_W-1:0] diff
);

    logic signed [SW:0] sum_w;
    logic signed [SW:0] diff_w;

    always_comb begin
        sum_w  = (SW+1)'(a) + (SW+1)'(b);
        diff_w = (SW+1)'(a) - (SW+1)'(b);
        sum    = sat_da(int'(sum_w));
        diff   = sat_da(int'(diff_w));
    end

endmodule

// File: rtl/dct_row_butterfly.sv
// Row DCT input stage: gathers 8 samples, level-shifts, and registers the
// even sums / odd differences for the DA coefficient units.
module dct_row_butterfly
    import dct_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   pix_valid,
    input  logic [IN_W-1:0]        pix_data,
    input  logic                   pix_sync,
    output logic signed [DA_W-1:0] even0,
    output logic signed [DA_W-1:0] even1,
    output logic signed [DA_W-1:0] even2,
    output logic signed [DA_W-1:0] even3,
    output logic signed [DA_W-1:0] odd0,
    output logic signed [DA_W-1:0] odd1,
    output logic signed [DA_W-1:0] odd2,
    output logic signed [DA_W-1:0] odd3,
    output logic                   DA_start,
    output logic [2:0]             row_idx,
    output logic                   blk_last
);

    localparam int SW = IN_W + 1;

    logic signed [SW-1:0]   s_in;
    logic signed [SW-1:0]   samp [DCT_N];
    logic [2:0]             col_cnt;
    logic [2:0]             row_cnt;
    logic signed [DA_W-1:0] sum_c  [4];
    logic signed [DA_W-1:0] diff_c [4];
    logic signed [DA_W-1:0] even_q [4];
    logic signed [DA_W-1:0] odd_q  [4];

    always_comb begin
        if (LEVEL_SHIFT != 0)
            s_in = $signed({1'b0, pix_data}) - $signed({2'b01, {(IN_W-1){1'b0}}});
        else
            s_in = $signed({pix_data[IN_W-1], pix_data});
    end

    // x7 is never stored: pair 0 takes it straight from the live input
    for (genvar k = 0; k < 4; k++) begin : g_pair
        dct_bfly_pair #(.SW(SW)) u_pair (
            .a    (samp[k]),
            .b    ((k == 0) ? s_in : samp[7-k]),
            .sum  (sum_c[k]),
            .diff (diff_c[k])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            row_idx  <= '0;
            DA_start <= 1'b0;
            blk_last <= 1'b0;
            for (int unsigned i = 0; i < DCT_N; i++)
                samp[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                even_q[i] <= '0;
                odd_q[i]  <= '0;
            end
        end else begin
            DA_start <= 1'b0;
            blk_last <= 1'b0;
            if (pix_valid) begin
                // sync outranks completion so a resync at col 7 never pulses
                if (pix_sync) begin
                    samp[0] <= s_in;
                    col_cnt <= 3'd1;
                    row_cnt <= '0;
                end else if (col_cnt == 3'(DCT_N-1)) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        even_q[i] <= sum_c[i];
                        odd_q[i]  <= diff_c[i];
                    end
                    DA_start <= 1'b1;
                    row_idx  <= row_cnt;
                    blk_last <= (row_cnt == 3'd7);
                    row_cnt  <= row_cnt + 3'd1;
                    col_cnt  <= '0;
                end else begin
                    samp[col_cnt] <= s_in;
                    col_cnt       <= col_cnt + 3'd1;
                end
            end
        end
    end

    assign even0 = even_q[0];
    assign even1 = even_q[1];
    assign even2 = even_q[2];
    assign even3 = even_q[3];
    assign odd0  = odd_q[0];
    assign odd1  = odd_q[1];
    assign odd2  = odd_q[2];
    assign odd3  = odd_q[3];

endmodule

// File: tb/tb_dct_row_butterfly.sv
// Bench for dct_row_butterfly: an 8-bit level-shifted instance and a 12-bit signed instance.
module tb_dct_row_butterfly;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    logic              v8 = 1'b0, s8 = 1'b0, v12 = 1'b0, s12 = 1'b0;
    logic [7:0]        d8 = '0;
    logic [11:0]       d12 = '0;
    logic signed [11:0] ev8 [4], od8 [4], ev12 [4], od12 [4];
    logic              da8, bl8, da12, bl12;
    logic [2:0]        ri8, ri12;

    always #5 sys_clk = ~sys_clk;

    dct_row_butterfly #(.IN_W(8), .LEVEL_SHIFT(1)) dut8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_valid(v8), .pix_data(d8), .pix_sync(s8),
        .even0(ev8[0]), .even1(ev8[1]), .even2(ev8[2]), .even3(ev8[3]),
        .odd0(od8[0]), .odd1(od8[1]), .odd2(od8[2]), .odd3(od8[3]),
        .DA_start(da8), .row_idx(ri8), .blk_last(bl8)
    );

    dct_row_butterfly #(.IN_W(12), .LEVEL_SHIFT(0)) dut12 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_valid(v12), .pix_data(d12), .pix_sync(s12),
        .even0(ev12[0]), .even1(ev12[1]), .even2(ev12[2]), .even3(ev12[3]),
        .odd0(od12[0]), .odd1(od12[1]), .odd2(od12[2]), .odd3(od12[3]),
        .DA_start(da12), .row_idx(ri12), .blk_last(bl12)
    );

    int total = 0;
    int bad = 0;
    int npulse = 0;

    // reference model: per-unit row queue and expected output state
    int rowq [2][$];
    int m_row [2];
    int m_even [2][4];
    int m_odd [2][4];
    int m_start [2];
    int m_blk [2];
    int m_ridx [2];

    function automatic int conv(input int u, input int x);
        if (u == 0) return x - 128;
        return (x >= 2048) ? x - 4096 : x;
    endfunction

    function automatic int sat(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic cmp(input string tag, input logic signed [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int u = 0; u < 2; u++) begin
            rowq[u].delete();
            m_row[u] = 0; m_start[u] = 0; m_blk[u] = 0; m_ridx[u] = 0;
            for (int k = 0; k < 4; k++) begin
                m_even[u][k] = 0;
                m_odd[u][k]  = 0;
            end
        end
    endtask

    task automatic mdl(input int u, input bit valid, input int x, input bit sync);
        int a, b;
        m_start[u] = 0;
        m_blk[u]   = 0;
        if (!valid) return;
        if (sync) begin
            rowq[u].delete();
            m_row[u] = 0;
        end
        rowq[u].push_back(conv(u, x));
        if (rowq[u].size() == 8) begin
            for (int k = 0; k < 4; k++) begin
                a = rowq[u][k];
                b = rowq[u][7-k];
                m_even[u][k] = sat(a + b);
                m_odd[u][k]  = sat(a - b);
            end
            m_start[u] = 1;
            m_ridx[u]  = m_row[u];
            m_blk[u]   = (m_row[u] == 7) ? 1 : 0;
            m_row[u]   = (m_row[u] + 1) % 8;
            rowq[u].delete();
        end
    endtask

    task automatic check_unit(input int u);
        logic signed [11:0] e [4];
        logic signed [11:0] o [4];
        logic da, bl;
        logic [2:0] ri;
        if (u == 0) begin
            e = ev8; o = od8; da = da8; bl = bl8; ri = ri8;
        end else begin
            e = ev12; o = od12; da = da12; bl = bl12; ri = ri12;
        end
        cmp($sformatf("u%0d_DA_start", u), 32'(da), m_start[u]);
        cmp($sformatf("u%0d_blk_last", u), 32'(bl), m_blk[u]);
        cmp($sformatf("u%0d_row_idx", u), 32'(ri), m_ridx[u]);
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("u%0d_even%0d", u, k), 32'(e[k]), m_even[u][k]);
            cmp($sformatf("u%0d_odd%0d", u, k), 32'(o[k]), m_odd[u][k]);
        end
    endtask

    task automatic step(input int u, input bit valid, input int x, input bit sync);
        @(negedge sys_clk);
        check_unit(0);
        check_unit(1);
        if (da8 === 1'b1) npulse++;
        if (u == 0) begin
            v8 = valid; d8 = 8'(x); s8 = sync; v12 = 1'b0; s12 = 1'b0;
        end else begin
            v12 = valid; d12 = 12'(x); s12 = sync; v8 = 1'b0; s8 = 1'b0;
        end
        if (sys_rst_n) begin
            mdl(0, (u == 0) && valid, x, sync);
            mdl(1, (u == 1) && valid, x, sync);
        end
    endtask

    task automatic row_const(input int u, input int x);
        for (int i = 0; i < 8; i++) step(u, 1'b1, x, 1'b0);
    endtask

    initial begin
        reset_model();
        // reset state
        step(0, 1'b0, 0, 1'b0);
        step(0, 1'b0, 0, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 1: flat mid-grey row
        row_const(0, 128);
        step(0, 1'b0, 0, 1'b0);
        cmp("t1_even0", 32'(ev8[0]), 0);
        cmp("t1_odd3", 32'(od8[3]), 0);

        // 2: ramp 0..7
        for (int i = 0; i < 8; i++) step(0, 1'b1, i, 1'b0);
        step(0, 1'b0, 0, 1'b0);
        cmp("t2_even2", 32'(ev8[2]), -249);
        cmp("t2_odd0", 32'(od8[0]), -7);
        cmp("t2_odd3", 32'(od8[3]), -1);
        cmp("t2_row_idx", 32'(ri8), 1);

        // 3: all white, then again with gaps mid-row and before x7
        row_const(0, 255);
        step(0, 1'b0, 0, 1'b0);
        cmp("t3_even1", 32'(ev8[1]), 254);
        for (int i = 0; i < 8; i++) begin
            if (i == 4 || i == 7)
                for (int g = 0; g < 3; g++) step(0, 1'b0, 0, 1'b0);
            step(0, 1'b1, 255, 1'b0);
        end
        step(0, 1'b0, 0, 1'b0);

        // 4: full block after sync, then one more row to see the wrap
        npulse = 0;
        for (int i = 0; i < 64; i++) step(0, 1'b1, int'($urandom_range(0, 255)), (i == 0));
        for (int i = 0; i < 8; i++) step(0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        step(0, 1'b0, 0, 1'b0);
        cmp("t4_pulses", npulse, 9);
        cmp("t4_wrap_row_idx", 32'(ri8), 0);

        // 5: partial row discarded by sync; sync without valid ignored; sync at col 7
        for (int i = 0; i < 5; i++) step(0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        step(0, 1'b0, 0, 1'b1);
        step(0, 1'b1, 10, 1'b1);
        for (int i = 1; i < 8; i++) step(0, 1'b1, 10 + 20 * i, 1'b0);
        step(0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 7; i++) step(0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        step(0, 1'b1, 200, 1'b1);
        for (int i = 1; i < 8; i++) step(0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        step(0, 1'b0, 0, 1'b0);

        // 6: 12-bit signed column pass, saturation of the odd set
        for (int i = 0; i < 8; i++) step(1, 1'b1, (i < 4) ? 2047 : 2048, 1'b0);
        step(1, 1'b0, 0, 1'b0);
        cmp("t6_even0", 32'(ev12[0]), -1);
        cmp("t6_odd2", 32'(od12[2]), 2047);
        for (int r = 0; r < 6; r++)
            for (int i = 0; i < 8; i++) step(1, 1'b1, int'($urandom_range(0, 4095)), 1'b0);
        step(1, 1'b0, 0, 1'b0);

        // 7: reset at sample x4, then a clean row
        for (int i = 0; i < 4; i++) step(0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        @(negedge sys_clk);
        check_unit(0);
        check_unit(1);
        sys_rst_n = 1'b0;
        v8 = 1'b1; d8 = 8'd99; s8 = 1'b0;
        #1;
        reset_model();
        check_unit(0);
        check_unit(1);
        step(0, 1'b0, 0, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 1'b1, int'($urandom_range(0, 255)), 1'b0);
        step(0, 1'b0, 0, 1'b0);
        step(0, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
